// File: rtl/load_ctrl_if.sv
// Command, AXI read and SRAM write signals of the load controller.
// master is the controller side, slave is the requester/AXI/SRAM environment.
interface load_ctrl_if;
    logic [1:0]  req_vld;
    logic [1:0]  req_rdy;
    logic [15:0] req_id;
    logic [23:0] req_dram_addr;
    logic [15:0] req_len;
    logic [5:0]  req_size;
    logic [15:0] req_sram_addr;

    logic [7:0]  axi_arid;
    logic [11:0] axi_araddr;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [1:0]  axi_arburst;
    logic        axi_arvld;
    logic        axi_arrdy;

    logic [7:0]  axi_rid;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rlast;
    logic        axi_rvld;
    logic        axi_rrdy;

    logic        sram_vld;
    logic        sram_wen;
    logic [7:0]  sram_addr;
    logic [31:0] sram_din;

    logic        done_vld;
    logic        done_req;
    logic        done_err;
    logic        busy;

    modport master (
        input  req_vld, req_id, req_dram_addr, req_len, req_size, req_sram_addr,
        output req_rdy,
        output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvld,
        input  axi_arrdy,
        input  axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvld,
        output axi_rrdy,
        output sram_vld, sram_wen, sram_addr, sram_din,
        output done_vld, done_req, done_err, busy
    );

    modport slave (
        output req_vld, req_id, req_dram_addr, req_len, req_size, req_sram_addr,
        input  req_rdy,
        input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvld,
        output axi_arrdy,
        output axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvld,
        input  axi_rrdy,
        input  sram_vld, sram_wen, sram_addr, sram_din,
        input  done_vld, done_req, done_err, busy
    );
endinterface

// File: rtl/load_ctrl.sv
// Load controller: round-robin grant of two loaders, one AXI read burst per command, beats to SRAM.
// Define LOAD_CTRL_RETRY_EN to re-issue errored bursts up to MAX_RETRY times.
module load_ctrl #(
    parameter int unsigned MAX_RETRY = 2
) (
    input logic         clk,
    input logic         rst,
    load_ctrl_if.master bus
);

    typedef enum logic [2:0] {StIdle, StAr, StData, StResp, StDone} state_e;

    state_e      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        gnt_q, gnt_d;
    logic        pick;
    logic [7:0]  id_q, id_d;
    logic [11:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [2:0]  size_q, size_d;
    logic [7:0]  base_q, base_d;
    logic [7:0]  beat_cnt_q, beat_cnt_d;
    logic        err_q, err_d;
    logic        wr_en;
    logic        at_len;
    logic [1:0]  req_rdy;
    logic        arvld;
    logic        rrdy;
    logic        sram_vld_q;
    logic [7:0]  sram_addr_q;
    logic [31:0] sram_din_q;

    if (MAX_RETRY > 7) begin : gen_max_retry_range
        $error("MAX_RETRY must be in 0..7");
    end

`ifdef LOAD_CTRL_RETRY_EN
    localparam logic [2:0] MaxRetry = 3'(MAX_RETRY);
    logic [2:0] retry_cnt_q, retry_cnt_d;
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        id_d       = id_q;
        addr_d     = addr_q;
        len_d      = len_q;
        size_d     = size_q;
        base_d     = base_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        req_rdy    = 2'b00;
        arvld      = 1'b0;
        rrdy       = 1'b0;
        wr_en      = 1'b0;
        pick       = bus.req_vld[ptr_q] ? ptr_q : ~ptr_q;
        at_len     = (beat_cnt_q == len_q);
`ifdef LOAD_CTRL_RETRY_EN
        retry_cnt_d = retry_cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (|bus.req_vld) begin
                    req_rdy = pick ? 2'b10 : 2'b01;
                    gnt_d   = pick;
                    id_d    = pick ? bus.req_id[15:8]         : bus.req_id[7:0];
                    addr_d  = pick ? bus.req_dram_addr[23:12] : bus.req_dram_addr[11:0];
                    len_d   = pick ? bus.req_len[15:8]        : bus.req_len[7:0];
                    size_d  = pick ? bus.req_size[5:3]        : bus.req_size[2:0];
                    base_d  = pick ? bus.req_sram_addr[15:8]  : bus.req_sram_addr[7:0];
`ifdef LOAD_CTRL_RETRY_EN
                    retry_cnt_d = 3'd0;
`endif
                    state_d = StAr;
                end
            end
            StAr: begin
                arvld = 1'b1;
                if (bus.axi_arrdy) begin
                    beat_cnt_d = 8'd0;
                    err_d      = 1'b0;
                    state_d    = StData;
                end
            end
            StData: begin
                rrdy = 1'b1;
                if (bus.axi_rvld) begin
                    if (bus.axi_rid == id_q) begin
                        wr_en      = 1'b1;
                        beat_cnt_d = beat_cnt_q + 8'd1;
                        // A length/rlast disagreement still ends the burst, but flags it.
                        if ((bus.axi_rresp != 2'b00) || (bus.axi_rlast != at_len)) begin
                            err_d = 1'b1;
                        end
                        if (bus.axi_rlast || at_len) begin
                            state_d = StResp;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StResp: begin
`ifdef LOAD_CTRL_RETRY_EN
                if (err_q && (retry_cnt_q < MaxRetry)) begin
                    retry_cnt_d = retry_cnt_q + 3'd1;
                    state_d     = StAr;
                end else begin
                    state_d = StDone;
                end
`else
                state_d = StDone;
`endif
            end
            StDone: begin
                ptr_d   = ~gnt_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= 1'b0;
            gnt_q       <= 1'b0;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            base_q      <= '0;
            beat_cnt_q  <= '0;
            err_q       <= 1'b0;
            sram_vld_q  <= 1'b0;
            sram_addr_q <= '0;
            sram_din_q  <= '0;
`ifdef LOAD_CTRL_RETRY_EN
            retry_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            base_q      <= base_d;
            beat_cnt_q  <= beat_cnt_d;
            err_q       <= err_d;
            sram_vld_q  <= wr_en;
            if (wr_en) begin
                sram_addr_q <= base_q + beat_cnt_q;
                sram_din_q  <= bus.axi_rdata;
            end
`ifdef LOAD_CTRL_RETRY_EN
            retry_cnt_q <= retry_cnt_d;
`endif
        end
    end

    assign bus.req_rdy     = req_rdy;
    assign bus.axi_arid    = id_q;
    assign bus.axi_araddr  = addr_q;
    assign bus.axi_arlen   = len_q;
    assign bus.axi_arsize  = size_q;
    assign bus.axi_arburst = 2'b01;
    assign bus.axi_arvld   = arvld;
    assign bus.axi_rrdy    = rrdy;
    assign bus.sram_vld    = sram_vld_q;
    assign bus.sram_wen    = sram_vld_q;
    assign bus.sram_addr   = sram_addr_q;
    assign bus.sram_din    = sram_din_q;
    assign bus.done_vld    = (state_q == StDone);
    assign bus.done_req    = (state_q == StDone) & gnt_q;
    assign bus.done_err    = (state_q == StDone) & err_q;
    assign bus.busy        = (state_q != StIdle);

endmodule

// File: tb/tb_load_ctrl.sv
// Self-checking bench for load_ctrl: table of single-burst vectors plus round-robin and reset sequences.
// Expectations follow LOAD_CTRL_RETRY_EN the same way the design does.
module tb_load_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_ctrl_if bus ();

    load_ctrl #(.MAX_RETRY(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // fault: 0 none, 1 rresp error on beat 1, 2 rlast on beat 2, 3 bad rid before beat 1,
    // 4 no rlast on final beat. The first nerr issues of the command carry the fault.
    typedef struct {
        logic       r;
        logic [7:0] id;
        logic [11:0] addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [7:0] base;
        int         fault;
        int         nerr;
        int         ar_delay;
        int         exp_ars;
        logic       exp_err;
    } tv_t;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    int  n_chk  = 0;
    int  n_pass = 0;
    wr_t wr_q[$];
    int  done_cnt  = 0;
    int  both_rdy  = 0;
    int  wen_diff  = 0;
    tv_t tv[8];

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endfunction

    function automatic tv_t mk(logic r, logic [7:0] id, logic [11:0] addr, logic [7:0] len,
                               logic [7:0] base, int fault, int nerr, int dly, int ars,
                               logic err);
        tv_t v;
        v.r = r; v.id = id; v.addr = addr; v.len = len; v.size = 3'd2; v.base = base;
        v.fault = fault; v.nerr = nerr; v.ar_delay = dly; v.exp_ars = ars; v.exp_err = err;
        return v;
    endfunction

    always @(posedge clk) begin
        if (bus.sram_vld === 1'b1) wr_q.push_back('{a: bus.sram_addr, d: bus.sram_din});
        if (bus.sram_vld !== bus.sram_wen) wen_diff++;
        if (bus.done_vld === 1'b1) done_cnt++;
        if (bus.req_rdy === 2'b11) both_rdy++;
    end

    task automatic set_slot(input logic r, input tv_t v);
        if (r) begin
            bus.req_id[15:8] = v.id;   bus.req_dram_addr[23:12] = v.addr;
            bus.req_len[15:8] = v.len; bus.req_size[5:3] = v.size;
            bus.req_sram_addr[15:8] = v.base;
        end else begin
            bus.req_id[7:0] = v.id;    bus.req_dram_addr[11:0] = v.addr;
            bus.req_len[7:0] = v.len;  bus.req_size[2:0] = v.size;
            bus.req_sram_addr[7:0] = v.base;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_vld = 2'b00; bus.req_id = '0; bus.req_dram_addr = '0; bus.req_len = '0;
        bus.req_size = '0; bus.req_sram_addr = '0; bus.axi_arrdy = 1'b0;
        bus.axi_rid = '0; bus.axi_rdata = '0; bus.axi_rresp = '0; bus.axi_rlast = 1'b0;
        bus.axi_rvld = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] rid, input logic [31:0] d, input logic [1:0] resp,
                             input logic last);
        bus.axi_rvld = 1'b1; bus.axi_rid = rid; bus.axi_rdata = d;
        bus.axi_rresp = resp; bus.axi_rlast = last;
        @(negedge clk);
        bus.axi_rvld = 1'b0; bus.axi_rlast = 1'b0; bus.axi_rresp = 2'b00;
    endtask

    // Entered on the negedge after the accept edge; leaves on the first idle negedge.
    task automatic serve(input tv_t v);
        wr_t exp_q[$];
        wr_q.delete();
        done_cnt = 0;
        for (int is = 0; is < v.exp_ars; is++) begin
            logic flt;
            int   last_k;
            logic [31:0] d;
            flt = (is < v.nerr);
            check((is == 0) ? "ar_latency" : "retry_ar", bus.axi_arvld, 1);
            if (bus.axi_arvld !== 1'b1) return;
            repeat (v.ar_delay) @(negedge clk);
            check("ar_hold", bus.axi_arvld, 1);
            check("arid", bus.axi_arid, v.id);
            check("araddr", bus.axi_araddr, v.addr);
            check("arlen", bus.axi_arlen, v.len);
            check("arsize", bus.axi_arsize, v.size);
            check("arburst", bus.axi_arburst, 2'b01);
            bus.axi_arrdy = 1'b1;
            @(negedge clk);
            bus.axi_arrdy = 1'b0;
            check("rrdy", bus.axi_rrdy, 1);
            last_k = (flt && v.fault == 2) ? 2 : int'(v.len);
            for (int k = 0; k <= last_k; k++) begin
                d = {v.id, 8'(is), 8'(k), 8'hA0 + 8'(k)};
                if (flt && v.fault == 3 && k == 1) send_beat(~v.id, 32'hDEAD_BEEF, 2'b00, 1'b0);
                send_beat(v.id, d, (flt && v.fault == 1 && k == 1) ? 2'b10 : 2'b00,
                          (k == last_k) && !(flt && v.fault == 4));
                exp_q.push_back('{a: v.base + 8'(k), d: d});
            end
            check("resp_no_done", bus.done_vld, 0);
            @(negedge clk);
            if (is < v.exp_ars - 1) continue;
            check("done_vld", bus.done_vld, 1);
            check("done_req", bus.done_req, v.r);
            check("done_err", bus.done_err, v.exp_err);
            @(negedge clk);
            check("busy_idle", bus.busy, 0);
        end
        check("done_count", done_cnt, 1);
        check("wr_count", wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            check("sram_addr", wr_q[i].a, exp_q[i].a);
            check("sram_din", wr_q[i].d, exp_q[i].d);
        end
    endtask

    initial begin
        tv_t junk, a, b;
        junk = mk(1'b0, 8'hEE, 12'hEEE, 8'h0E, 8'hE0, 0, 0, 0, 1, 1'b0);
        junk.size = 3'd7;
        tv[0] = mk(1'b0, 8'h11, 12'h100, 8'd3, 8'h20, 0, 0, 0, 1, 1'b0);
        tv[1] = mk(1'b1, 8'h5A, 12'hABC, 8'd0, 8'h07, 0, 0, 2, 1, 1'b0);
        tv[2] = mk(1'b0, 8'h33, 12'h040, 8'd3, 8'hFE, 0, 0, 0, 1, 1'b0);
`ifdef LOAD_CTRL_RETRY_EN
        tv[3] = mk(1'b1, 8'h42, 12'h200, 8'd3, 8'h10, 1, 1, 0, 2, 1'b0);
        tv[4] = mk(1'b0, 8'h43, 12'h300, 8'd3, 8'h30, 1, 3, 1, 3, 1'b1);
        tv[5] = mk(1'b0, 8'h44, 12'h400, 8'd3, 8'h50, 2, 3, 0, 3, 1'b1);
        tv[6] = mk(1'b1, 8'h45, 12'h500, 8'd2, 8'h70, 3, 3, 0, 3, 1'b1);
        tv[7] = mk(1'b0, 8'h46, 12'h600, 8'd2, 8'h90, 4, 1, 0, 2, 1'b0);
`else
        tv[3] = mk(1'b1, 8'h42, 12'h200, 8'd3, 8'h10, 1, 1, 0, 1, 1'b1);
        tv[4] = mk(1'b0, 8'h43, 12'h300, 8'd3, 8'h30, 1, 3, 1, 1, 1'b1);
        tv[5] = mk(1'b0, 8'h44, 12'h400, 8'd3, 8'h50, 2, 3, 0, 1, 1'b1);
        tv[6] = mk(1'b1, 8'h45, 12'h500, 8'd2, 8'h70, 3, 3, 0, 1, 1'b1);
        tv[7] = mk(1'b0, 8'h46, 12'h600, 8'd2, 8'h90, 4, 1, 0, 1, 1'b1);
`endif

        do_reset();
        #1;
        check("rst_req_rdy", bus.req_rdy, 0);
        check("rst_arvld", bus.axi_arvld, 0);
        check("rst_rrdy", bus.axi_rrdy, 0);
        check("rst_sram", {bus.sram_vld, bus.sram_wen, bus.sram_addr, bus.sram_din[21:0]}, 0);
        check("rst_sram_din", bus.sram_din, 0);
        check("rst_done", {bus.done_vld, bus.done_req, bus.done_err, bus.busy}, 0);
        check("rst_ar_fields", {bus.axi_arid, bus.axi_araddr, bus.axi_arlen, bus.axi_arsize}, 0);
        check("rst_arburst", bus.axi_arburst, 2'b01);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            set_slot(tv[i].r, tv[i]);
            set_slot(~tv[i].r, junk);
            bus.req_vld = tv[i].r ? 2'b10 : 2'b01;
            #1;
            check("grant", bus.req_rdy, tv[i].r ? 2'b10 : 2'b01);
            @(negedge clk);
            bus.req_vld = 2'b00;
            serve(tv[i]);
        end

        // Both requesters held valid: grants alternate starting from requester 0.
        do_reset();
        a = mk(1'b0, 8'h21, 12'h210, 8'd1, 8'h40, 0, 0, 0, 1, 1'b0);
        b = mk(1'b1, 8'h31, 12'h310, 8'd2, 8'h60, 0, 0, 0, 1, 1'b0);
        set_slot(1'b0, a);
        set_slot(1'b1, b);
        bus.req_vld = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_grant", bus.req_rdy, (i % 2) ? 2'b10 : 2'b01);
            @(negedge clk);
            serve((i % 2) ? b : a);
        end
        bus.req_vld = 2'b00;
        check("rdy_onehot", both_rdy, 0);

        // Reset mid-burst abandons the command and returns the pointer to 0.
        do_reset();
        set_slot(1'b0, a);
        set_slot(1'b1, b);
        bus.req_vld = 2'b01;
        #1;
        check("pre_grant", bus.req_rdy, 2'b01);
        @(negedge clk);
        bus.req_vld = 2'b00;
        serve(a);
        bus.req_vld = 2'b11;
        #1;
        check("ptr_moved", bus.req_rdy, 2'b10);
        @(negedge clk);
        bus.req_vld = 2'b00;
        bus.axi_arrdy = 1'b1;
        @(negedge clk);
        bus.axi_arrdy = 1'b0;
        send_beat(b.id, 32'h1, 2'b00, 1'b0);
        send_beat(b.id, 32'h2, 2'b00, 1'b0);
        done_cnt = 0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_rrdy_mid", bus.axi_rrdy, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_no_done", done_cnt, 0);
        bus.req_vld = 2'b11;
        #1;
        check("ptr_reset", bus.req_rdy, 2'b01);
        @(negedge clk);
        bus.req_vld = 2'b00;
        check("wen_eq_vld", wen_diff, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/load_ctrl.md
# load_ctrl

Load controller that sequences DRAM-to-SRAM load commands for the accelerator's load path. It arbitrates two load requesters (weight and activation loaders) with round-robin priority and drives the AXI read address channel. It consumes R-channel beats, writes each accepted beat into the internal SRAM at an incrementing address, and checks response and length. On error it retries the whole burst a bounded number of times.

## Interface
- MAX_RETRY, 2, maximum re-issues of one command after an errored burst (0..7)
- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- req_vld  in  2  per-requester command valid (bit n = requester n)
- req_rdy  out  2  per-requester command accept, one-hot or zero
- req_id  in  16  {id1,id0}, 8 b each, AXI ARID for the command
- req_dram_addr  in  24  {a1,a0}, 12 b DRAM byte address each
- req_len  in  16  {l1,l0}, 8 b AXI length each (beats = len+1)
- req_size  in  6  {s1,s0}, 3 b AXI size each
- req_sram_addr  in  16  {b1,b0}, 8 b SRAM base word address each
- axi_arid / axi_araddr / axi_arlen / axi_arsize  out  8/12/8/3  latched command fields
- axi_arburst  out  2  constant 2'b01 (INCR)
- axi_arvld  out  1  AR valid;  axi_arrdy  in  1  AR ready
- axi_rid  in  8;  axi_rdata  in  32;  axi_rresp  in  2;  axi_rlast  in  1;  axi_rvld  in  1
- axi_rrdy  out  1  R ready
- sram_vld / sram_wen  out  1/1  SRAM access strobe and write enable (always equal)
- sram_addr  out  8;  sram_din  out  32  registered write address/data
- done_vld  out  1  one-cycle completion pulse;  done_req  out  1  requester index;  done_err  out  1  final burst errored
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, AR, DATA, RESP, DONE.
- IDLE: if any req_vld, grant by round-robin. Priority pointer names the preferred requester and resets to 0. Assert req_rdy[g] combinationally that cycle, latch id/addr/len/size/sram base of g, clear retry_cnt, go AR. req_rdy is 0 in all other states.
- AR: axi_arvld=1 with latched fields, held stable until axi_arvld&axi_arrdy. Then clear beat_cnt and err, go DATA.
- DATA: axi_rrdy=1. Each rvld&rrdy beat:
  - rid == latched id: write rdata to SRAM at base+beat_cnt (8-bit add, wraps 255->0), beat_cnt++; rresp != 0 sets err.
  - rid mismatch: beat is dropped (no SRAM write, no count) and err is set.
  - The matching beat with rlast, or the beat where beat_cnt == len, goes to RESP. rlast with beat_cnt != len, or beat_cnt == len without rlast, sets err.
- RESP: if err and retry_cnt < MAX_RETRY, retry_cnt++ and go AR; the same SRAM range is rewritten. Otherwise go DONE.
- DONE: done_vld=1, done_req=g, done_err=err. Pointer becomes ~g. Go IDLE.
- beat_cnt 8 b, retry_cnt 3 b. Dropped beats do not end the burst.

## Timing
- Reset values: state IDLE, axi_arvld 0, axi_rrdy 0, req_rdy 0, sram_vld/wen 0, sram_addr 0, sram_din 0, done_vld/done_req/done_err 0, busy 0, all AR fields 0, pointer 0.
- Accept at cycle t, axi_arvld=1 from t+1. Earliest R beat accepted is the cycle after the AR handshake.
- SRAM write is registered: a beat at cycle t gives sram_vld=1 at t+1 for one cycle. Back-to-back beats give back-to-back writes.
- Last beat at t: RESP at t+1, DONE (done_vld) at t+2, IDLE at t+3. The earliest new accept is at t+3.
- Retry: the RESP cycle at t+1 is followed by axi_arvld at t+2.
- Both req_vld high in IDLE: the pointer's requester wins; the loser keeps req_vld and is granted next.
- rst mid-burst: immediate return to IDLE at the next edge. The pending burst is abandoned, no done_vld, and the pointer returns to 0.

## Configuration
- LOAD_CTRL_RETRY_EN defined: retry logic as above.
- LOAD_CTRL_RETRY_EN undefined: retry_cnt is removed and MAX_RETRY is ignored. RESP always goes to DONE, with done_err reporting err.

## Test plan
- req_vld=01, id0=0x11, addr0=0x100, len0=3, base0=0x20, 4 clean beats 0xA0..A3 -> sram writes 0x20..0x23 with data A0..A3; done_vld one cycle 2 cycles after last beat; done_req=0; done_err=0.
- req_vld=11 held, pointer 0 -> grant order 0,1,0,1 with each burst clean; req_rdy never both high.
- base=0xFE, len=3 -> SRAM addresses FE, FF, 00, 01.
- First burst beat 1 rresp=2, then clean reissue, MAX_RETRY=2 -> two AR handshakes with identical fields; done_err=0. With the macro undefined -> one AR and done_err=1.
- Every burst errored, MAX_RETRY=2 -> exactly 3 AR handshakes, then done_err=1.
- rlast on beat 2 with len=3 -> done_err set; a rid-mismatched beat mid-burst -> no SRAM write and err set; rst asserted during DATA -> busy=0 and axi_rrdy=0 next cycle, no done_vld.
